score_display_scan: RTL and testbench



---
 rtl/disp_pkg.sv | 68 ++++++
 rtl/bin2bcd_seq.sv | 89 ++++++++
 rtl/score_display_scan.sv | 145 ++++++++++++++
 tb/tb_score_display_scan.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants, state encoding and helpers for the score display path.
package disp_pkg;

    // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low anode patterns for the four used digit positions
    localparam logic [7:0] AN_OFF         = 8'hFF;
    localparam logic [7:0] AN_SCORE_UNITS = 8'b11111110;
    localparam logic [7:0] AN_SCORE_TENS  = 8'b11111101;
    localparam logic [7:0] AN_HIGH_UNITS  = 8'b10111111;
    localparam logic [7:0] AN_HIGH_TENS   = 8'b01111111;

    // Three BCD nibbles: hundreds, tens, units
    localparam int BCD_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_e;

    // Decode one BCD digit; anything outside 0-9 is blanked rather than undefined
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Add 3 to every nibble that is 5 or more, ahead of the double-dabble shift
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to three-nibble BCD converter.
// The result register only changes when a conversion completes, so it can be
// displayed directly without tearing.
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int VAL_W = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [VAL_W-1:0]   bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    // Iteration counter is 3 bits wide; it counts VAL_W-1 down to 0
    localparam logic [2:0] CNT_INIT = 3'(VAL_W - 1);

    conv_state_e        state_r;
    logic [VAL_W-1:0]   bin_r;
    logic [BCD_W-1:0]   acc_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W-1:0]   step_s;
    logic [2:0]         cnt_r;
    logic               busy_r;
    logic               done_r;

    // One double-dabble iteration: adjust nibbles, then shift in the binary MSB
    always_comb begin
        adj_s  = bcd_adjust(acc_r);
        step_s = {adj_s[BCD_W-2:0], bin_r[VAL_W-1]};
    end

    // Converter FSM and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            bin_r   <= '0;
            acc_r   <= '0;
            bcd_r   <= '0;
            cnt_r   <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r <= ST_LOAD;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    bin_r   <= bin;
                    acc_r   <= '0;
                    cnt_r   <= CNT_INIT;
                    state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    acc_r <= step_s;
                    bin_r <= {bin_r[VAL_W-2:0], 1'b0};
                    if (cnt_r == 3'd0) begin
                        bcd_r   <= step_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = bcd_r;

endmodule

// File: rtl/score_display_scan.sv
// Converts score / high score to BCD and scans them onto four digits of the
// 8-digit seven-segment display (score on AN[1:0], high score on AN[7:6]).
module score_display_scan
    import disp_pkg::*;
#(
    parameter int REFRESH_BITS = 15,
    parameter int VAL_W        = 7,
    parameter int BLANK_LEAD   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VAL_W-1:0] score,
    input  logic [VAL_W-1:0] high_score,
    input  logic             update,
    output logic             busy,
    output logic [6:0]       seg0,
    output logic [7:0]       AN
);

    logic                     busy_a_s;
    logic                     busy_b_s;
    logic                     done_a_s;
    logic                     done_b_s;
    logic                     ready_s;
    logic                     start_s;
    logic                     pending_r;
    logic [BCD_W-1:0]         score_bcd_s;
    logic [BCD_W-1:0]         high_bcd_s;
    logic                     score_over_s;
    logic                     high_over_s;
    logic [REFRESH_BITS-1:0]  refresh_r;
    logic [1:0]               sel_s;
    logic [7:0]               an_s;
    logic [6:0]               seg_s;
    logic [7:0]               an_r;
    logic [6:0]               seg_r;

    // A new conversion may start when both converters are idle or just finished
    always_comb begin
        ready_s = (done_a_s & done_b_s) | ~(busy_a_s | busy_b_s);
        start_s = ready_s & (update | pending_r);
    end

    // Hold at most one deferred update request; it is consumed at the next start
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= 1'b0;
        end else if (start_s) begin
            pending_r <= 1'b0;
        end else if (update) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    bin2bcd_seq #(.VAL_W(VAL_W)) u_conv_score (
        .clk   (clk),
        .reset (reset),
        .start (start_s),
        .bin   (score),
        .busy  (busy_a_s),
        .done  (done_a_s),
        .bcd   (score_bcd_s)
    );

    bin2bcd_seq #(.VAL_W(VAL_W)) u_conv_high (
        .clk   (clk),
        .reset (reset),
        .start (start_s),
        .bin   (high_score),
        .busy  (busy_b_s),
        .done  (done_b_s),
        .bcd   (high_bcd_s)
    );

    // Pick the anode and segment pattern for the digit currently selected
    always_comb begin
        an_s         = AN_OFF;
        seg_s        = SEG_BLANK;
        sel_s        = refresh_r[REFRESH_BITS-1 -: 2];
        score_over_s = (score_bcd_s[11:8] != 4'd0);
        high_over_s  = (high_bcd_s[11:8] != 4'd0);
        case (sel_s)
            2'd0: begin
                an_s = AN_SCORE_UNITS;
                if (score_over_s) begin
                    seg_s = SEG_DASH;
                end else begin
                    seg_s = bcd_to_seg(score_bcd_s[3:0]);
                end
            end
            2'd1: begin
                an_s = AN_SCORE_TENS;
                if (score_over_s) begin
                    seg_s = SEG_DASH;
                end else if ((BLANK_LEAD != 0) && (score_bcd_s[7:4] == 4'd0)) begin
                    seg_s = SEG_BLANK;
                end else begin
                    seg_s = bcd_to_seg(score_bcd_s[7:4]);
                end
            end
            2'd2: begin
                an_s = AN_HIGH_UNITS;
                if (high_over_s) begin
                    seg_s = SEG_DASH;
                end else begin
                    seg_s = bcd_to_seg(high_bcd_s[3:0]);
                end
            end
            2'd3: begin
                an_s = AN_HIGH_TENS;
                if (high_over_s) begin
                    seg_s = SEG_DASH;
                end else if ((BLANK_LEAD != 0) && (high_bcd_s[7:4] == 4'd0)) begin
                    seg_s = SEG_BLANK;
                end else begin
                    seg_s = bcd_to_seg(high_bcd_s[7:4]);
                end
            end
            default: begin
                an_s  = AN_OFF;
                seg_s = SEG_BLANK;
            end
        endcase
    end

    // Free-running refresh counter and the registered anode/segment outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_r <= '0;
            an_r      <= AN_OFF;
            seg_r     <= SEG_BLANK;
        end else begin
            refresh_r <= refresh_r + REFRESH_BITS'(1);
            an_r      <= an_s;
            seg_r     <= seg_s;
        end
    end

    assign busy = busy_a_s;
    assign seg0 = seg_r;
    assign AN   = an_r;

endmodule

// File: tb/tb_score_display_scan.sv
// Self-checking bench for score_display_scan with a short refresh counter.
module tb_score_display_scan;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                           S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000,
                           S9 = 7'b0000100, DSH = 7'b1111110, BLK = 7'b1111111;

    typedef struct {
        logic [6:0] sc;
        logic [6:0] hi;
        logic [6:0] su;
        logic [6:0] st;
        logic [6:0] hu;
        logic [6:0] ht;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [6:0] score;
    logic [6:0] high_score;
    logic       update;
    logic       busy;
    logic [6:0] seg0;
    logic [7:0] AN;

    int total;
    int bad;
    vec_t vecs[7];
    vec_t sb_q[$];

    score_display_scan #(.REFRESH_BITS(4), .VAL_W(7), .BLANK_LEAD(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .score      (score),
        .high_score (high_score),
        .update     (update),
        .busy       (busy),
        .seg0       (seg0),
        .AN         (AN)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return S0;
            1: return S1;
            2: return S2;
            3: return S3;
            4: return S4;
            5: return S5;
            6: return S6;
            7: return S7;
            8: return S8;
            9: return S9;
            default: return BLK;
        endcase
    endfunction

    // Reference: segment pattern expected for the digit that AN selects
    function automatic logic [6:0] exp_seg(input logic [7:0] an, input int s, input int h);
        int v;
        int d;
        bit tens;
        case (an)
            8'b11111110: begin v = s; tens = 1'b0; end
            8'b11111101: begin v = s; tens = 1'b1; end
            8'b10111111: begin v = h; tens = 1'b0; end
            8'b01111111: begin v = h; tens = 1'b1; end
            default: return BLK;
        endcase
        if (v > 99) return DSH;
        d = tens ? (v / 10) : (v % 10);
        if (tens && d == 0) return BLK;
        return digit_seg(d);
    endfunction

    // Watch a full scan period and record the segment pattern seen at each digit
    task automatic scan(output logic [6:0] su, output logic [6:0] st,
                        output logic [6:0] hu, output logic [6:0] ht);
        su = 7'bx; st = 7'bx; hu = 7'bx; ht = 7'bx;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("an_unused_high", {28'd0, AN[5:2]}, 32'hF);
            case (AN)
                8'b11111110: su = seg0;
                8'b11111101: st = seg0;
                8'b10111111: hu = seg0;
                8'b01111111: ht = seg0;
                default: ;
            endcase
        end
    endtask

    initial begin
        vec_t e;
        logic [6:0] su, st, hu, ht;
        int n;

        total = 0;
        bad = 0;
        vecs[0] = '{sc: 7'd47,  hi: 7'd93,  su: S7,  st: S4,  hu: S3,  ht: S9};
        vecs[1] = '{sc: 7'd0,   hi: 7'd99,  su: S0,  st: BLK, hu: S9,  ht: S9};
        vecs[2] = '{sc: 7'd9,   hi: 7'd0,   su: S9,  st: BLK, hu: S0,  ht: BLK};
        vecs[3] = '{sc: 7'd10,  hi: 7'd100, su: S0,  st: S1,  hu: DSH, ht: DSH};
        vecs[4] = '{sc: 7'd99,  hi: 7'd127, su: S9,  st: S9,  hu: DSH, ht: DSH};
        vecs[5] = '{sc: 7'd100, hi: 7'd10,  su: DSH, st: DSH, hu: S0,  ht: S1};
        vecs[6] = '{sc: 7'd127, hi: 7'd9,   su: DSH, st: DSH, hu: S9,  ht: BLK};

        // Reset and the first few refresh positions, including the wrap
        reset = 1'b1; update = 1'b0; score = 7'd0; high_score = 7'd0;
        tick(); tick(); tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_an", {24'd0, AN}, 32'hFF);
        check("rst_seg", {25'd0, seg0}, {25'd0, BLK});
        tick();
        check("scan0_an", {24'd0, AN}, 32'hFE);
        check("scan0_seg", {25'd0, seg0}, {25'd0, S0});
        repeat (4) tick();
        check("scan1_an", {24'd0, AN}, 32'hFD);
        check("scan1_seg", {25'd0, seg0}, {25'd0, BLK});
        repeat (4) tick();
        check("scan2_an", {24'd0, AN}, 32'hBF);
        check("scan2_seg", {25'd0, seg0}, {25'd0, S0});
        repeat (4) tick();
        check("scan3_an", {24'd0, AN}, 32'h7F);
        check("scan3_seg", {25'd0, seg0}, {25'd0, BLK});
        repeat (4) tick();
        check("wrap_an", {24'd0, AN}, 32'hFE);

        // Table of conversions through the scoreboard
        for (int k = 0; k < 7; k++) begin
            score = vecs[k].sc;
            high_score = vecs[k].hi;
            update = 1'b1;
            sb_q.push_back(vecs[k]);
            tick();
            update = 1'b0;
            n = 0;
            while (busy === 1'b1 && n < 30) begin
                n++;
                tick();
            end
            check("busy_cycles", n, 8);
            e = sb_q.pop_front();
            scan(su, st, hu, ht);
            check("score_units", {25'd0, su}, {25'd0, e.su});
            check("score_tens", {25'd0, st}, {25'd0, e.st});
            check("high_units", {25'd0, hu}, {25'd0, e.hu});
            check("high_tens", {25'd0, ht}, {25'd0, e.ht});
        end

        // Busy collision: 12 first, one merged pending request then shows 35
        score = 7'd12; high_score = 7'd0; update = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            update = (k >= 4 && k <= 7);
            if (k == 4) score = 7'd35;
            check("coll_busy1", {31'd0, busy}, 32'd1);
            tick();
        end
        update = 1'b0;
        check("coll_gap", {31'd0, busy}, 32'd0);
        tick();
        for (int k = 10; k <= 18; k++) begin
            check("coll_seg12", {25'd0, seg0}, {25'd0, exp_seg(AN, 12, 0)});
            check("coll_busy2", {31'd0, busy}, (k <= 17) ? 32'd1 : 32'd0);
            tick();
        end
        for (int k = 19; k <= 34; k++) begin
            check("coll_seg35", {25'd0, seg0}, {25'd0, exp_seg(AN, 35, 0)});
            check("coll_no_third", {31'd0, busy}, 32'd0);
            tick();
        end

        // Reset in the middle of converting 88
        score = 7'd88; high_score = 7'd88; update = 1'b1;
        tick();
        update = 1'b0;
        repeat (4) tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_an", {24'd0, AN}, 32'hFF);
        check("mid_rst_seg", {25'd0, seg0}, {25'd0, BLK});
        for (int k = 0; k < 20; k++) begin
            tick();
            check("post_rst_busy", {31'd0, busy}, 32'd0);
            check("post_rst_seg", {25'd0, seg0}, {25'd0, exp_seg(AN, 0, 0)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
